// File: rtl/fec_codec_ctrl.sv
// fec_codec_ctrl: gathers M payload symbols, hands them to an external
// codec datapath, waits CODEC_LAT cycles and streams the results back out.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cfg_we/sel/row/col    coefficient write (sel 0 = decode, 1 = encode)
//   cfg_data, cfg_ready   coefficient value, write accepted this cycle
//   in_valid/ready/data   payload symbol input stream
//   out_valid/ready/data  processed symbol output stream
//   out_last              marks the final symbol of a block
//   codec_symbols_in      captured block driven to the codec
//   codec_decode_coeffs   decode coefficient matrix driven to the codec
//   codec_encode_coeffs   encode coefficient matrix driven to the codec
//   codec_symbols_out     codec result, sampled after CODEC_LAT cycles
//   blk_count             completed block count (wraps)
module fec_codec_ctrl #(
   parameter  int M         = 3,
   parameter  int WIDTH     = 11,
   parameter  int CODEC_LAT = 1,
   localparam int DATA_W    = WIDTH - 1,
   localparam int IW        = (M > 1) ? $clog2(M) : 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               cfg_we,
   input  logic                               cfg_sel,
   input  logic [IW-1:0]                      cfg_row,
   input  logic [IW-1:0]                      cfg_col,
   input  logic [WIDTH-1:0]                   cfg_data,
   output logic                               cfg_ready,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [DATA_W-1:0]                  in_data,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [DATA_W-1:0]                  out_data,
   output logic                               out_last,
   output logic [M-1:0][DATA_W-1:0]           codec_symbols_in,
   output logic [M-1:0][M-1:0][WIDTH-1:0]     codec_decode_coeffs,
   output logic [M-1:0][M-1:0][WIDTH-1:0]     codec_encode_coeffs,
   input  logic [M-1:0][DATA_W-1:0]           codec_symbols_out,
   output logic [15:0]                        blk_count
);

   typedef enum logic [1:0] {
      COLLECT,
      COMPUTE,
      EMIT
   } state_t;

   state_t                    state;
   state_t                    state_nx;
   logic [IW-1:0]             idx;
   logic [IW-1:0]             odx;
   logic [3:0]                wcnt;
   logic [M-1:0][DATA_W-1:0]  cap;
   logic [M-1:0][DATA_W-1:0]  obuf;

   logic in_hs;
   logic out_hs;
   logic cfg_hs;
   logic idx_last;
   logic odx_last;
   logic wait_done;
   logic row_ok;

   assign idx_last  = idx == IW'(M - 1);
   assign odx_last  = odx == IW'(M - 1);
   assign wait_done = (state == COMPUTE)
                   && (wcnt == 4'(CODEC_LAT - 1));
   assign in_hs     = in_valid && in_ready;
   assign out_hs    = out_valid && out_ready;
   assign cfg_hs    = cfg_we && cfg_ready;
   assign row_ok    = (int'(cfg_row) < M)
                   && (int'(cfg_col) < M);

   assign codec_symbols_in = cap;
   assign out_data         = obuf[odx];
   assign out_last         = out_valid && odx_last;

   // Handshake readiness is masked by rst_n so nothing looks
   // ready while reset is held, yet rises as soon as it lifts.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      cfg_ready = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         COLLECT: begin
            in_ready  = rst_n;
            cfg_ready = rst_n && (idx == '0);
            if (rst_n && in_valid && idx_last)
               state_nx = COMPUTE;
         end
         COMPUTE: begin
            if (wait_done)
               state_nx = EMIT;
         end
         EMIT: begin
            out_valid = 1'b1;
            if (out_ready && odx_last)
               state_nx = COLLECT;
         end
         default: state_nx = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= COLLECT;
         idx       <= '0;
         odx       <= '0;
         wcnt      <= '0;
         cap       <= '0;
         obuf      <= '0;
         blk_count <= '0;
      end else begin
         state <= state_nx;
         if (in_hs) begin
            cap[idx] <= in_data;
            idx      <= idx_last ? '0 : idx + 1'b1;
         end
         if (state == COMPUTE)
            wcnt <= wait_done ? '0 : wcnt + 1'b1;
         if (wait_done)
            obuf <= codec_symbols_out;
         if (out_hs) begin
            odx <= odx_last ? '0 : odx + 1'b1;
            if (odx_last)
               blk_count <= blk_count + 16'd1;
         end
      end
   end

   // Both matrices come out of reset as identity (passthrough).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < M; r++) begin
            for (int c = 0; c < M; c++) begin
               codec_decode_coeffs[r][c] <=
                  (r == c) ? WIDTH'(1) : '0;
               codec_encode_coeffs[r][c] <=
                  (r == c) ? WIDTH'(1) : '0;
            end
         end
      end else if (cfg_hs && row_ok) begin
         if (cfg_sel)
            codec_encode_coeffs[cfg_row][cfg_col] <= cfg_data;
         else
            codec_decode_coeffs[cfg_row][cfg_col] <= cfg_data;
      end
   end

endmodule

// File: tb/tb_fec_codec_ctrl.sv
// tb_fec_codec_ctrl: scoreboard bench for fec_codec_ctrl with a
// behavioural codec and a matrix-level reference model.
`timescale 1ns/1ps
module tb_fec_codec_ctrl;

   localparam int M   = 3;
   localparam int W   = 11;
   localparam int DW  = W - 1;
   localparam int LAT = 2;
   localparam int IW  = 2;

   typedef logic [DW-1:0] blk_t [M];
   typedef struct {
      logic [DW-1:0] d;
      bit            last;
   } exp_t;

   logic                       clk = 1'b0;
   logic                       rst_n = 1'b0;
   logic                       cfg_we = 1'b0;
   logic                       cfg_sel = 1'b0;
   logic [IW-1:0]              cfg_row = '0;
   logic [IW-1:0]              cfg_col = '0;
   logic [W-1:0]               cfg_data = '0;
   logic                       cfg_ready;
   logic                       in_valid = 1'b0;
   logic                       in_ready;
   logic [DW-1:0]              in_data = '0;
   logic                       out_valid;
   logic                       out_ready = 1'b0;
   logic [DW-1:0]              out_data;
   logic                       out_last;
   logic [M-1:0][DW-1:0]       codec_symbols_in;
   logic [M-1:0][M-1:0][W-1:0] codec_decode_coeffs;
   logic [M-1:0][M-1:0][W-1:0] codec_encode_coeffs;
   logic [M-1:0][DW-1:0]       codec_symbols_out;
   logic [15:0]                blk_count;

   fec_codec_ctrl #(
      .M(M), .WIDTH(W), .CODEC_LAT(LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel),
      .cfg_row(cfg_row), .cfg_col(cfg_col),
      .cfg_data(cfg_data), .cfg_ready(cfg_ready),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last),
      .codec_symbols_in(codec_symbols_in),
      .codec_decode_coeffs(codec_decode_coeffs),
      .codec_encode_coeffs(codec_encode_coeffs),
      .codec_symbols_out(codec_symbols_out),
      .blk_count(blk_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          tests = 0;
   int          fails = 0;
   int          mdec [M][M];
   int          menc [M][M];
   exp_t        q [$];
   bit          lin = 1'b1;
   int          rmode = 0;
   int          credits = 0;
   int          last_hs = 0;
   logic [15:0] exp_blk = '0;

   // Codec stand-in: linear combination through the decode
   // matrix, or an ideal codec that returns the payload.
   always_comb begin
      logic [31:0] acc;
      acc = '0;
      codec_symbols_out = '0;
      for (int i = 0; i < M; i++) begin
         acc = '0;
         for (int j = 0; j < M; j++)
            acc = acc + 32'(codec_decode_coeffs[i][j])
                      * 32'(codec_symbols_in[j]);
         codec_symbols_out[i] = lin ? acc[DW-1:0]
                                    : codec_symbols_in[i];
      end
   end

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", nm, act, req);
      end
   endtask

   function automatic void model_reset();
      for (int r = 0; r < M; r++)
         for (int c = 0; c < M; c++) begin
            mdec[r][c] = (r == c) ? 1 : 0;
            menc[r][c] = (r == c) ? 1 : 0;
         end
   endfunction

   function automatic void model_cfg(input bit sel,
                                     input int r, input int c,
                                     input int v);
      if (r < M && c < M) begin
         if (sel) menc[r][c] = v;
         else     mdec[r][c] = v;
      end
   endfunction

   function automatic void push_block(input blk_t x);
      exp_t e;
      for (int i = 0; i < M; i++) begin
         int acc;
         acc = 0;
         if (lin) begin
            for (int j = 0; j < M; j++)
               acc += mdec[i][j] * int'(x[j]);
         end else begin
            acc = int'(x[i]);
         end
         e.d    = DW'(acc % (1 << DW));
         e.last = (i == M - 1);
         q.push_back(e);
      end
   endfunction

   task automatic check_mats();
      for (int r = 0; r < M; r++)
         for (int c = 0; c < M; c++) begin
            chk("dec_coef", codec_decode_coeffs[r][c], mdec[r][c]);
            chk("enc_coef", codec_encode_coeffs[r][c], menc[r][c]);
         end
   endtask

   task automatic cfg_write(input bit sel, input int r,
                            input int c, input int v,
                            input bit rdy);
      cfg_we   = 1'b1;
      cfg_sel  = sel;
      cfg_row  = IW'(r);
      cfg_col  = IW'(c);
      cfg_data = W'(v);
      chk("cfg_ready", cfg_ready, rdy);
      if (rdy) model_cfg(sel, r, c, v);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Leaves in_valid asserted at the negedge whose following
   // posedge performs the handshake.
   task automatic send_sym(input logic [DW-1:0] d);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL in_wait: got in_ready 0, want 1");
      end
   endtask

   task automatic send_block(input blk_t x, input bit gaps,
                             input bit wcfg, input bit sel,
                             input int r, input int c,
                             input int v);
      for (int i = 0; i < M; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         if (i == 0 && wcfg) begin
            cfg_we   = 1'b1;
            cfg_sel  = sel;
            cfg_row  = IW'(r);
            cfg_col  = IW'(c);
            cfg_data = W'(v);
         end
         send_sym(x[i]);
         if (i == 0 && wcfg) begin
            chk("cfg_with_data", cfg_ready, 1);
            model_cfg(sel, r, c, v);
         end
         if (i == M - 1) last_hs = cyc + 1;
         @(negedge clk);
         in_valid = 1'b0;
         cfg_we   = 1'b0;
      end
      push_block(x);
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("drain_left", q.size(), 0);
      @(negedge clk);
      chk("blk_count", blk_count, exp_blk);
      chk("in_ready_after", in_ready, 1);
   endtask

   task automatic wait_one_out();
      int t;
      t = 0;
      while (q.size() != M - 1 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("first_out", q.size(), M - 1);
   endtask

   function automatic blk_t rnd_blk();
      blk_t x;
      for (int i = 0; i < M; i++) x[i] = DW'($urandom);
      return x;
   endfunction

   // Monitor: drives out_ready, pops the scoreboard on each
   // output handshake and checks hold/latency/overlap rules.
   initial begin
      bit            pv;
      bit            pr;
      logic [DW-1:0] pd;
      bit            pl;
      exp_t          e;
      pv = 0; pr = 0; pd = '0; pl = 0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (pv && !pr) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_data", out_data, pd);
               chk("hold_last", out_last, pl);
            end
            if (out_valid && !pv)
               chk("latency", cyc, last_hs + LAT);
            if (out_valid)
               chk("no_overlap", in_ready, 0);
         end
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = 1'b0;
            default: out_ready = (credits > 0);
         endcase
         if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_out: got %0d, want none",
                        out_data);
            end else begin
               e = q.pop_front();
               chk("out_data", out_data, e.d);
               chk("out_last", out_last, e.last);
               if (e.last) exp_blk = exp_blk + 16'd1;
               if (rmode == 3) credits--;
            end
         end
         pv = rst_n && out_valid;
         pr = out_ready;
         pd = out_data;
         pl = out_last;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      blk_t x;
      int   dec_v [M][M];
      int   enc_v [M][M];
      dec_v = '{'{1, 511, 256}, '{0, 682, 853}, '{0, 853, 597}};
      enc_v = '{'{1, 1, 1}, '{0, 2, 4}, '{0, 4, 16}};
      model_reset();

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_blk", blk_count, 0);
      chk("rst_sym_in", codec_symbols_in, 0);
      check_mats();
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", in_ready, 1);
      chk("rel_cfg_ready", cfg_ready, 1);
      @(negedge clk);

      // Passthrough of 5,6,7
      rmode = 0;
      x = '{10'd5, 10'd6, 10'd7};
      send_block(x, 0, 0, 0, 0, 0, 0);
      wait_drain();

      // Load the decode/encode matrices, ideal codec
      for (int r = 0; r < M; r++)
         for (int c = 0; c < M; c++) begin
            cfg_write(0, r, c, dec_v[r][c], 1);
            cfg_write(1, r, c, enc_v[r][c], 1);
         end
      check_mats();
      lin = 1'b0;
      x = '{10'd753, 10'd1000, 10'd748};
      send_block(x, 0, 0, 0, 0, 0, 0);
      wait_drain();
      lin = 1'b1;

      // Stall at odx=1 for 5 cycles
      rmode   = 3;
      credits = 1;
      send_block(rnd_blk(), 0, 0, 0, 0, 0, 0);
      wait_one_out();
      repeat (5) begin
         @(negedge clk);
         chk("stall_valid", out_valid, 1);
         chk("stall_data", out_data, q[0].d);
         chk("stall_in_ready", in_ready, 0);
      end
      rmode = 0;
      wait_drain();

      // Write attempt at idx=1 is dropped
      x = rnd_blk();
      send_sym(x[0]);
      @(negedge clk);
      in_valid = 1'b0;
      cfg_write(0, 0, 0, 7, 0);
      for (int i = 1; i < M; i++) begin
         send_sym(x[i]);
         if (i == M - 1) last_hs = cyc + 1;
         @(negedge clk);
         in_valid = 1'b0;
      end
      push_block(x);
      wait_drain();
      check_mats();

      // Randomized traffic and configuration
      for (int b = 0; b < 40; b++) begin
         bit wc;
         rmode = 1;
         wc = ($urandom_range(0, 2) == 0);
         send_block(rnd_blk(), 1, wc, 1'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 2047));
         if (b % 8 == 7) begin
            wait_drain();
            repeat (3)
               cfg_write(1'($urandom), $urandom_range(0, 3),
                         $urandom_range(0, 3),
                         $urandom_range(0, 2047), 1);
            check_mats();
         end
      end
      rmode = 0;
      wait_drain();

      // Reset during EMIT at odx=1
      rmode   = 3;
      credits = 1;
      send_block(rnd_blk(), 0, 0, 0, 0, 0, 0);
      wait_one_out();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_cfg_ready", cfg_ready, 0);
      chk("mid_rst_blk", blk_count, 0);
      q.delete();
      model_reset();
      exp_blk = '0;
      credits = 0;
      rmode   = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_mats();
      x = '{10'd1, 10'd2, 10'd3};
      send_block(x, 0, 0, 0, 0, 0, 0);
      wait_drain();

      // blk_count wrap
      force dut.blk_count = 16'hFFFF;
      @(negedge clk);
      release dut.blk_count;
      exp_blk = 16'hFFFF;
      send_block(rnd_blk(), 0, 0, 0, 0, 0, 0);
      wait_drain();
      chk("blk_wrap", blk_count, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fec_codec_ctrl.md
FEC_CODEC_CTRL -- requirements
Module: fec_codec_ctrl

Interface
REQ-001 Parameter M, default 3: symbols per coded block and coefficient matrix dimension.
REQ-002 Parameter WIDTH, default 11: coefficient and lifted-symbol width; DATA_W = WIDTH-1 is the payload symbol width.
REQ-003 Parameter CODEC_LAT, default 1, range 1..15: number of cycles codec inputs are held stable before codec outputs are sampled.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (all state on rising edge); rst_n input 1 (asynchronous assert, active low).
REQ-005 cfg_we input 1: coefficient write strobe.
REQ-006 cfg_sel input 1: 0 = decode matrix, 1 = encode matrix.
REQ-007 cfg_row, cfg_col input $clog2(M) each: matrix index.
REQ-008 cfg_data input WIDTH: coefficient value.
REQ-009 cfg_ready output 1: coefficient writes are accepted this cycle.
REQ-010 in_valid input 1, in_ready output 1, in_data input DATA_W: payload symbol stream.
REQ-011 out_valid output 1, out_ready input 1, out_data output DATA_W, out_last output 1: processed symbol stream.
REQ-012 codec_symbols_in output [M] x DATA_W, codec_decode_coeffs output [M][M] x WIDTH, codec_encode_coeffs output [M][M] x WIDTH: drive the codec datapath.
REQ-013 codec_symbols_out input [M] x DATA_W: codec result.
REQ-014 blk_count output 16: number of completed blocks, where a block is complete when its last output symbol has been accepted.

Function
REQ-015 The block SHALL implement the FSM states COLLECT, COMPUTE and EMIT.
REQ-016 COLLECT: in_ready=1; each in_valid&in_ready handshake stores in_data into capture register idx, then increments idx; the handshake at idx=M-1 resets idx to 0 and transitions to COMPUTE.
REQ-017 codec_symbols_in SHALL be driven continuously from the capture registers, which change only on COLLECT handshakes.
REQ-018 COMPUTE: in_ready=0; a wait counter runs for CODEC_LAT cycles; on the last cycle, codec_symbols_out is registered into the output buffer and the FSM goes to EMIT.
REQ-019 Latency: with the last input handshake at edge k, out_valid SHALL rise after edge k+CODEC_LAT.
REQ-020 EMIT: out_valid=1, out_data=buffer[odx], out_last=(odx==M-1); odx advances only on out_valid&out_ready.
REQ-021 out_data and out_last SHALL be held stable while out_valid=1 and out_ready=0.
REQ-022 On the out_last handshake the block SHALL increment blk_count (16-bit, wraps 0xFFFF->0x0000), reset odx to 0, and return to COLLECT.
REQ-023 In the cycle after the out_last handshake, in_ready=1; input and output SHALL NOT overlap.
REQ-024 cfg_ready=1 only when state==COLLECT and idx==0; this ensures coefficients never change while a block is partially captured or being computed.
REQ-025 cfg_we&cfg_ready SHALL write cfg_data to the selected matrix element on that edge.
REQ-026 cfg_we while cfg_ready=0 SHALL be ignored, with no state change.
REQ-027 A cfg write and an in_data handshake in the same cycle are both legal; the new coefficient applies to that block.
REQ-028 codec_decode_coeffs and codec_encode_coeffs SHALL be driven directly from the coefficient registers.
REQ-029 Out-of-range cfg_row or cfg_col (>=M) SHALL be ignored.

Reset
REQ-030 While rst_n=0, all outputs SHALL be as follows: state=COLLECT; idx=odx=0; in_ready=0; out_valid=0; out_last=0; out_data=0; capture regs and buffer=0; blk_count=0; cfg_ready=0.
REQ-031 On reset, both coefficient matrices SHALL be loaded with identity (1 on diagonal, 0 elsewhere), giving passthrough.
REQ-032 in_ready and cfg_ready SHALL assert in the first cycle after rst_n deasserts.
REQ-033 Reset asserted mid-COLLECT, COMPUTE or EMIT SHALL discard the partial block with no out_valid glitch; the next block starts at idx 0.

Verification
REQ-034 Reset then inputs 5,6,7 back-to-back, out_ready=1 -> out_data 5,6,7 with out_last on 7; blk_count=1; out_valid rises CODEC_LAT cycles after the 7 handshake.
REQ-035 Load decode rows {1,511,256},{0,682,853},{0,853,597} and encode rows {1,1,1},{0,2,4},{0,4,16}; inputs 753,1000,748 -> codec_decode_coeffs matches loaded values and outputs 753,1000,748.
REQ-036 Hold out_ready=0 for 5 cycles during EMIT at odx=1 -> out_data is held at symbol 1, in_ready=0, and no symbol is lost or duplicated.
REQ-037 With idx=1, drive cfg_we writing decode[0][0]=7 -> cfg_ready=0, the write is ignored, and the block still passes through unchanged.
REQ-038 Assert rst_n=0 during EMIT at odx=1, then release and send 1,2,3 -> outputs are exactly 1,2,3 and blk_count=1.
REQ-039 Preload blk_count to 0xFFFF by forcing, complete one block -> blk_count=0x0000.
